// File: rtl/freq_sweep_tuner.sv
// -----------------------------------------------------------------------------
// freq_sweep_tuner
//
// Linear frequency sweep tuner for the SWIPT drive path. On request it steps the
// drive frequency from f_start towards f_stop in f_step increments. At every
// point it waits for the synthesiser and rectifier to settle, averages
// 2^AVG_LOG2 valid ADC samples, and tracks the point with the highest average.
// When the sweep ends the drive is parked on that best frequency.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   swipt_alive  link alive; low returns to IDLE, keeps freq_out and best_*
//   go           level request to run a sweep; low aborts a running sweep
//   adc_valid    strobe qualifying adc
//   adc          rectified-power sample
//   f_start      first sweep frequency (used on start)
//   f_stop       last allowed sweep frequency (latched on start)
//   f_step       sweep increment (latched on start); zero gives a single point
//   freq_out     frequency word to the synthesiser
//   freq_strobe  one-cycle pulse whenever freq_out changes
//   best_freq    frequency with the highest average seen so far
//   best_adc     averaged ADC reading at best_freq
//   busy         high while a sweep is in progress
//   done         sweep complete, held until go drops
// -----------------------------------------------------------------------------
module freq_sweep_tuner #(
  parameter int FREQ_W         = 20,
  parameter int ADC_W          = 12,
  parameter int CNT_W          = 24,
  parameter int STARTUP_CYCLES = 200000,
  parameter int SETTLE_CYCLES  = 200000,
  parameter int AVG_LOG2       = 4,
  parameter logic [FREQ_W-1:0] F_DEFAULT = {FREQ_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              swipt_alive,
  input  logic              go,
  input  logic              adc_valid,
  input  logic [ADC_W-1:0]  adc,
  input  logic [FREQ_W-1:0] f_start,
  input  logic [FREQ_W-1:0] f_stop,
  input  logic [FREQ_W-1:0] f_step,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_strobe,
  output logic [FREQ_W-1:0] best_freq,
  output logic [ADC_W-1:0]  best_adc,
  output logic              busy,
  output logic              done
);

  // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples, so it never
  // overflows; the sample counter needs one extra bit to hold 2^AVG_LOG2.
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;

  localparam logic [N_W-1:0]   N_LAST       = N_W'((1 << AVG_LOG2) - 1);
  localparam logic [CNT_W-1:0] STARTUP_LOAD = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STARTUP = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t            state_r;
  logic [FREQ_W-1:0] freq_out_r;
  logic              freq_strobe_r;
  logic [FREQ_W-1:0] best_freq_r;
  logic [ADC_W-1:0]  best_adc_r;
  logic              busy_r;
  logic              done_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ACC_W-1:0]  acc_r;
  logic [N_W-1:0]    n_r;
  logic              first_r;
  logic [FREQ_W-1:0] f_stop_r;
  logic [FREQ_W-1:0] f_step_r;

  logic [ADC_W-1:0]  avg_s;
  logic [FREQ_W-1:0] cand_freq_s;
  logic [ADC_W-1:0]  cand_adc_s;
  logic [FREQ_W:0]   next_freq_s;
  logic              last_point_s;
  logic              sweeping_s;
  logic              abort_s;

  // Score the current point against the best so far and work out the next sweep step.
  always_comb begin
    avg_s        = acc_r[ACC_W-1:AVG_LOG2];
    cand_freq_s  = best_freq_r;
    cand_adc_s   = best_adc_r;
    next_freq_s  = {1'b0, freq_out_r} + {1'b0, f_step_r};
    last_point_s = 1'b0;
    // Strict comparison: on a tie the earlier (lower) frequency is kept.
    if (first_r || (avg_s > best_adc_r)) begin
      cand_freq_s = freq_out_r;
      cand_adc_s  = avg_s;
    end else begin
      cand_freq_s = best_freq_r;
      cand_adc_s  = best_adc_r;
    end
    // The carry bit catches a step past the top of the frequency word, so the
    // sweep stops instead of wrapping to a low frequency.
    if ((f_step_r == {FREQ_W{1'b0}}) || next_freq_s[FREQ_W] ||
        (next_freq_s[FREQ_W-1:0] > f_stop_r)) begin
      last_point_s = 1'b1;
    end else begin
      last_point_s = 1'b0;
    end
  end

  // Detect a go drop while a sweep is running.
  always_comb begin
    sweeping_s = 1'b0;
    case (state_r)
      ST_STARTUP, ST_SETTLE, ST_MEASURE, ST_COMPARE: sweeping_s = 1'b1;
      default:                                       sweeping_s = 1'b0;
    endcase
    if (sweeping_s && !go) begin
      abort_s = 1'b1;
    end else begin
      abort_s = 1'b0;
    end
  end

  // Sweep sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      freq_out_r    <= F_DEFAULT;
      freq_strobe_r <= 1'b0;
      best_freq_r   <= F_DEFAULT;
      best_adc_r    <= {ADC_W{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      acc_r         <= {ACC_W{1'b0}};
      n_r           <= {N_W{1'b0}};
      first_r       <= 1'b0;
      f_stop_r      <= {FREQ_W{1'b0}};
      f_step_r      <= {FREQ_W{1'b0}};
    end else if (!swipt_alive) begin
      // Link lost: park in IDLE, drive frequency and best result are kept.
      state_r       <= ST_IDLE;
      freq_strobe_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else if (abort_s) begin
      // Sweep cancelled: fall back to the best point found so far.
      state_r       <= ST_IDLE;
      freq_out_r    <= best_freq_r;
      freq_strobe_r <= (best_freq_r != freq_out_r);
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      freq_strobe_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (go) begin
            state_r       <= ST_STARTUP;
            f_stop_r      <= f_stop;
            f_step_r      <= f_step;
            freq_out_r    <= f_start;
            freq_strobe_r <= 1'b1;
            best_freq_r   <= f_start;
            best_adc_r    <= {ADC_W{1'b0}};
            first_r       <= 1'b1;
            cnt_r         <= STARTUP_LOAD;
            busy_r        <= 1'b1;
            done_r        <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_STARTUP, ST_SETTLE: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= ST_MEASURE;
            acc_r   <= {ACC_W{1'b0}};
            n_r     <= {N_W{1'b0}};
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end

        ST_MEASURE: begin
          if (adc_valid) begin
            acc_r <= acc_r + ACC_W'(adc);
            n_r   <= n_r + N_W'(1);
            if (n_r == N_LAST) begin
              state_r <= ST_COMPARE;
            end else begin
              state_r <= ST_MEASURE;
            end
          end else begin
            state_r <= ST_MEASURE;
          end
        end

        ST_COMPARE: begin
          first_r     <= 1'b0;
          best_freq_r <= cand_freq_s;
          best_adc_r  <= cand_adc_s;
          if (last_point_s) begin
            // Park on the winner in the same cycle done rises.
            state_r       <= ST_DONE;
            freq_out_r    <= cand_freq_s;
            freq_strobe_r <= (cand_freq_s != freq_out_r);
            busy_r        <= 1'b0;
            done_r        <= 1'b1;
          end else begin
            state_r       <= ST_SETTLE;
            freq_out_r    <= next_freq_s[FREQ_W-1:0];
            freq_strobe_r <= 1'b1;
            cnt_r         <= SETTLE_LOAD;
          end
        end

        ST_DONE: begin
          if (!go) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign freq_out    = freq_out_r;
  assign freq_strobe = freq_strobe_r;
  assign best_freq   = best_freq_r;
  assign best_adc    = best_adc_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_freq_sweep_tuner.sv
// -----------------------------------------------------------------------------
// Testbench for freq_sweep_tuner. Sweep scenarios come from a vector table and
// from random ranges; expected results come from the table and from a simple
// point-list model of the sweep. Hand-written sequences cover aborts, link
// loss, sample counting/averaging and mid-sweep reset.
// -----------------------------------------------------------------------------
module tb_freq_sweep_tuner;

  localparam int FW      = 20;
  localparam int AW      = 12;
  localparam int STARTUP = 4;
  localparam int SETTLE  = 3;
  localparam int ALOG2   = 2;
  localparam int NSAMP   = 1 << ALOG2;
  localparam int MAXP    = 16;
  localparam logic [FW-1:0] FDEF = 20'h00ABC;
  localparam longint MAXF = 64'd1048575;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          swipt_alive = 1'b1;
  logic          go = 1'b0;
  logic          adc_valid = 1'b0;
  logic [AW-1:0] adc = 12'd0;
  logic [FW-1:0] f_start = 20'd0;
  logic [FW-1:0] f_stop = 20'd0;
  logic [FW-1:0] f_step = 20'd0;
  logic [FW-1:0] freq_out;
  logic          freq_strobe;
  logic [FW-1:0] best_freq;
  logic [AW-1:0] best_adc;
  logic          busy;
  logic          done;

  freq_sweep_tuner #(
    .FREQ_W(FW), .ADC_W(AW), .CNT_W(24),
    .STARTUP_CYCLES(STARTUP), .SETTLE_CYCLES(SETTLE),
    .AVG_LOG2(ALOG2), .F_DEFAULT(FDEF)
  ) dut (
    .clk(clk), .rst(rst), .swipt_alive(swipt_alive), .go(go),
    .adc_valid(adc_valid), .adc(adc),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
    .freq_out(freq_out), .freq_strobe(freq_strobe),
    .best_freq(best_freq), .best_adc(best_adc),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  int nstrobe;
  int vmode;
  int pt_val[MAXP];
  longint visited[$];
  longint exp_pts[$];

  typedef struct {
    logic [FW-1:0] fs;
    logic [FW-1:0] fe;
    logic [FW-1:0] fp;
    int v0, v1, v2, v3;
    int vm;
    logic [FW-1:0] bf;
    int ba;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One cycle: sample at the falling edge, log strobes, drive the point's ADC value.
  task automatic step();
    int idx;
    @(negedge clk);
    cyc++;
    if (freq_strobe) begin
      visited.push_back(longint'(freq_out));
      nstrobe++;
    end
    idx = (nstrobe == 0) ? 0 : nstrobe - 1;
    if (idx >= MAXP) idx = MAXP - 1;
    if (vmode != 3) begin
      adc = AW'(pt_val[idx]);
      case (vmode)
        0: adc_valid = 1'b1;
        1: adc_valid = ((cyc % 3) == 0);
        default: adc_valid = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Reference: list of points the sweep must visit, from the range rules alone.
  task automatic model_points(input longint fs, input longint fe, input longint fp);
    longint f;
    exp_pts.delete();
    f = fs;
    while (1) begin
      exp_pts.push_back(f);
      if (fp == 0 || f + fp > fe || f + fp > MAXF) break;
      f = f + fp;
    end
  endtask

  task automatic run_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                           input logic [FW-1:0] fp, input int vm,
                           input logic [FW-1:0] eb_f, input int eb_a, input string tag);
    int np;
    int ret;
    model_points(fs, fe, fp);
    np = exp_pts.size();
    f_start = fs; f_stop = fe; f_step = fp; vmode = vm;
    go = 1'b1; cyc = 0; nstrobe = 0; visited.delete();
    while (!done && cyc < 3000) step();
    check($sformatf("%s_done", tag), done, 1);
    if (vm == 0)
      check($sformatf("%s_latency", tag), cyc,
            1 + STARTUP + np * (NSAMP + 1) + (np - 1) * SETTLE);
    check($sformatf("%s_best_freq", tag), best_freq, eb_f);
    check($sformatf("%s_best_adc", tag), best_adc, eb_a);
    check($sformatf("%s_freq_out", tag), freq_out, eb_f);
    check($sformatf("%s_busy", tag), busy, 0);
    ret = (exp_pts[np-1] != longint'(eb_f)) ? 1 : 0;
    check($sformatf("%s_nstrobes", tag), visited.size(), np + ret);
    for (int i = 0; i < np; i++)
      if (i < visited.size()) check($sformatf("%s_pt%0d", tag, i), visited[i], exp_pts[i]);
    if (ret == 1 && visited.size() > np)
      check($sformatf("%s_return", tag), visited[np], eb_f);
    go = 1'b0;
    step();
    check($sformatf("%s_done_clear", tag), done, 0);
    check($sformatf("%s_park", tag), freq_out, eb_f);
  endtask

  initial begin
    int bi;
    logic [FW-1:0] rfs, rfe, rfp;
    int n;

    tbl[0] = '{20'd100, 20'd130, 20'd10, 50, 80, 200, 120, 0, 20'd120, 200};
    tbl[1] = '{20'd100, 20'd130, 20'd10, 90, 90, 90, 90, 0, 20'd100, 90};
    tbl[2] = '{20'd100, 20'd130, 20'd0, 77, 1, 1, 1, 0, 20'd100, 77};
    tbl[3] = '{20'hFFFF0, 20'hFFFFF, 20'h00020, 33, 1, 1, 1, 0, 20'hFFFF0, 33};
    tbl[4] = '{20'd200, 20'd150, 20'd10, 40, 1, 1, 1, 0, 20'd200, 40};
    tbl[5] = '{20'd100, 20'd120, 20'd10, 10, 300, 300, 0, 1, 20'd110, 300};
    tbl[6] = '{20'd100, 20'd120, 20'd10, 5, 6, 7, 0, 0, 20'd120, 7};
    tbl[7] = '{20'd100, 20'd130, 20'd10, 400, 300, 200, 100, 2, 20'd100, 400};

    // Reset state
    vmode = 3; cyc = 0; nstrobe = 0;
    repeat (3) step();
    check("rst_freq_out", freq_out, FDEF);
    check("rst_best_freq", best_freq, FDEF);
    check("rst_best_adc", best_adc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobe", freq_strobe, 0);
    rst = 1'b0;
    step();

    // Table-driven sweeps
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < MAXP; i++) pt_val[i] = 0;
      pt_val[0] = tbl[t].v0; pt_val[1] = tbl[t].v1;
      pt_val[2] = tbl[t].v2; pt_val[3] = tbl[t].v3;
      run_sweep(tbl[t].fs, tbl[t].fe, tbl[t].fp, tbl[t].vm, tbl[t].bf, tbl[t].ba,
                $sformatf("vec%0d", t));
    end

    // Randomized sweeps against the point-list model
    for (int it = 0; it < 12; it++) begin
      if (it % 4 == 3) begin
        rfs = 20'hFFFFF - FW'($urandom_range(0, 100));
        rfe = 20'hFFFFF;
        rfp = FW'($urandom_range(20, 50));
      end else begin
        rfs = FW'($urandom_range(1, 1000));
        rfp = FW'($urandom_range(0, 50));
        n = $urandom_range(1, 8);
        rfe = rfs + rfp * FW'(n - 1) +
              ((rfp > 0) ? FW'($urandom_range(0, int'(rfp) - 1)) : FW'($urandom_range(0, 30)));
        if (it % 5 == 4) rfe = rfs - 20'd1;
      end
      for (int i = 0; i < MAXP; i++) pt_val[i] = $urandom_range(0, (it % 2 == 1) ? 3 : 4095);
      model_points(rfs, rfe, rfp);
      bi = 0;
      for (int i = 1; i < exp_pts.size(); i++) if (pt_val[i] > pt_val[bi]) bi = i;
      run_sweep(rfs, rfe, rfp, (it % 3 == 0) ? 0 : 2, FW'(exp_pts[bi]), pt_val[bi],
                $sformatf("rnd%0d", it));
    end

    // go dropped during SETTLE of the third point
    for (int i = 0; i < MAXP; i++) pt_val[i] = 0;
    pt_val[0] = 50; pt_val[1] = 80; pt_val[2] = 200; pt_val[3] = 120;
    f_start = 20'd100; f_stop = 20'd130; f_step = 20'd10; vmode = 0;
    go = 1'b1; cyc = 0; nstrobe = 0; visited.delete();
    while (nstrobe < 3 && cyc < 200) step();
    check("abort_reached_pt3", nstrobe, 3);
    go = 1'b0;
    step();
    check("abort_freq_out", freq_out, 110);
    check("abort_strobe", freq_strobe, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_best_adc", best_adc, 80);
    step();
    check("abort_strobe_once", freq_strobe, 0);

    // swipt_alive low during MEASURE of the second point, then a fresh sweep
    pt_val[0] = 60; pt_val[1] = 70;
    f_start = 20'd100; go = 1'b1; cyc = 0; nstrobe = 0; visited.delete();
    while (cyc < 14) step();
    swipt_alive = 1'b0;
    step();
    check("alive_busy", busy, 0);
    check("alive_done", done, 0);
    check("alive_freq_hold", freq_out, 110);
    check("alive_best_freq", best_freq, 100);
    check("alive_best_adc", best_adc, 60);
    step();
    check("alive_stay_idle", busy, 0);
    f_start = 20'd300; swipt_alive = 1'b1;
    step();
    check("restart_freq_out", freq_out, 300);
    check("restart_strobe", freq_strobe, 1);
    check("restart_busy", busy, 1);
    check("restart_best_adc", best_adc, 0);
    check("restart_best_freq", best_freq, 300);
    go = 1'b0;
    step();
    check("restart_abort_busy", busy, 0);

    // Sparse valids: sample count and floor average (1+2+3+5)/4 = 2
    vmode = 3; adc_valid = 1'b0;
    f_start = 20'd500; f_stop = 20'd900; f_step = 20'd0;
    go = 1'b1; cyc = 0; nstrobe = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      adc_valid = 1'b1;
      case (cyc)
        2:  adc = 12'd4000;
        5:  adc = 12'd1;
        8:  adc = 12'd2;
        11: adc = 12'd3;
        14: adc = 12'd5;
        default: begin adc_valid = 1'b0; adc = 12'd4095; end
      endcase
      if (cyc == 15) check("avg_not_early", done, 0);
      if (cyc == 16) begin
        check("avg_done", done, 1);
        check("avg_best_adc", best_adc, 2);
        check("avg_best_freq", best_freq, 500);
      end
    end
    adc_valid = 1'b0; go = 1'b0;
    step();

    // Reset in the middle of a sweep
    f_start = 20'd700; f_step = 20'd5; go = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midrst_freq_out", freq_out, FDEF);
    check("midrst_best_freq", best_freq, FDEF);
    check("midrst_busy", busy, 0);
    rst = 1'b0; go = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_sweep_tuner.md
# freq_sweep_tuner

Parametrised successor to the SWIPT single-step frequency tuner. It runs a configurable linear sweep of the drive frequency from `f_start` to `f_stop` in steps of `f_step`. At each point it waits a settle interval, then averages 2^AVG_LOG2 valid ADC samples. When the sweep ends it parks the drive on the frequency with the highest averaged ADC reading. It sits between the SWIPT control FSM, which supplies `go` and `swipt_alive`, and the frequency synthesiser, which consumes `freq_out`.

## Interface
- FREQ_W, 20: frequency word width
- ADC_W, 12: ADC sample width
- CNT_W, 24: startup/settle counter width
- STARTUP_CYCLES, 200000: wait after start before the first measurement (2 ms @ 100 MHz)
- SETTLE_CYCLES, 200000: wait after each frequency change
- AVG_LOG2, 4: log2 of samples averaged per point (0..8)
- F_DEFAULT, 0: `freq_out`/`best_freq` value after reset
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- swipt_alive  in  1  link alive; low aborts like reset (except F_DEFAULT reload, see below)
- go  in  1  level request to run a sweep
- adc_valid  in  1  `adc` sample strobe
- adc  in  ADC_W  rectified-power sample
- f_start / f_stop / f_step  in  FREQ_W each  sweep range; sampled on start, held internally
- freq_out  out  FREQ_W  frequency to synthesiser
- freq_strobe  out  1  one-cycle pulse on each `freq_out` change
- best_freq  out  FREQ_W  best frequency so far
- best_adc  out  ADC_W  averaged ADC at best_freq
- busy  out  1  sweep in progress
- done  out  1  sweep complete, held until `go` low

## Operation
- States: IDLE, STARTUP, SETTLE, MEASURE, COMPARE, DONE.
- Reset (`rst`=1): state IDLE, `freq_out`=`best_freq`=F_DEFAULT, `best_adc`=0, `busy`=`done`=`freq_strobe`=0, counters and accumulator 0.
- `swipt_alive`=0 in any state: go to IDLE, `done`=0, `busy`=0. `freq_out` holds its value. `best_*` are retained.
- IDLE to STARTUP when `go`&`swipt_alive`. Latch range. `freq_out`<=`f_start`, `freq_strobe`=1, `best_freq`<=`f_start`, `best_adc`<=0, first-point flag set, cnt<=STARTUP_CYCLES-1.
- STARTUP/SETTLE: cnt decrements each cycle. At cnt==0, enter MEASURE with acc<=0 and n<=0.
- MEASURE: on each `adc_valid`, acc+=adc (acc width ADC_W+AVG_LOG2, no overflow possible) and n++. When n reaches 2^AVG_LOG2, go to COMPARE. Samples arriving outside MEASURE are ignored.
- COMPARE (1 cycle): avg=acc>>AVG_LOG2.
  - If first point or avg > `best_adc` (strict), `best_adc`<=avg and `best_freq`<=`freq_out`. Clear first flag.
  - Next = `freq_out`+`f_step`, computed in FREQ_W+1 bits.
  - If `f_step`==0, or next > `f_stop`, or next overflows: go to DONE.
  - Else `freq_out`<=next, `freq_strobe`=1, cnt<=SETTLE_CYCLES-1, go to SETTLE.
- DONE: `freq_out`<=`best_freq` (strobe only if the value changes), `done`=1. Stay until `go`=0, then IDLE with `done`<=0.
- `go` falling in STARTUP/SETTLE/MEASURE/COMPARE: abort to IDLE, `freq_out`<=current `best_freq` (strobe if changed), `done` stays 0.
- `f_stop` < `f_start`: single point at `f_start`, then DONE.
- Ties keep the earlier (lower) frequency.
- `busy`=1 in STARTUP, SETTLE, MEASURE, COMPARE.

## Timing
- All outputs registered. `freq_out` and `freq_strobe` update in the same cycle.
- Start: `go` sampled high in IDLE gives `freq_out`=`f_start` and `busy`=1 on the next edge.
- First MEASURE entry is STARTUP_CYCLES cycles after STARTUP entry.
- Per-point cost: SETTLE_CYCLES + (cycles to collect 2^AVG_LOG2 valids) + 1 COMPARE cycle.
- Last COMPARE to `done`=1: 1 cycle. `freq_out`=`best_freq` in the same cycle as `done`.
- `rst` has priority over `swipt_alive`, which has priority over `go`.

## Test plan
- Reset, then params STARTUP=4, SETTLE=3, AVG_LOG2=2; f_start=100, f_stop=130, f_step=10; adc_valid every cycle with adc = 50/80/200/120 per point -> points 100, 110, 120, 130 visited; `best_freq`=120, `best_adc`=200, `done`=1, `freq_out`=120; 4 strobes for the sweep plus 1 on return to 120.
- Ties: adc 90 at every point -> `best_freq`=100. f_step=0 -> one point, `done` after first COMPARE.
- Overflow: f_start=0xFFFF0, f_step=0x20, f_stop=0xFFFFF -> single point then DONE, no wrap to low frequency.
- `go` dropped during SETTLE of the 3rd point (best so far 110) -> IDLE, `freq_out`=110, `done`=0, `busy`=0.
- `swipt_alive` low during MEASURE -> IDLE next cycle. Re-raise with `go` high -> fresh sweep from `f_start`, `best_adc` cleared.
- adc_valid every 3rd cycle, AVG_LOG2=2 -> COMPARE occurs exactly after the 4th valid. Average equals floor(sum/4), e.g. samples 1, 2, 3, 5 -> `best_adc`=2.
